// File: rtl/apb_master_bridge.sv
// APB requester bridge: one command at a time from a valid/ready port, two-phase APB transfer, response on valid/ready.
// Define APB_TIMEOUT_EN to abort an ACCESS phase with rsp_err after TIMEOUT cycles without pready.
module apb_master_bridge #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("apb_master_bridge: TIMEOUT must be in 1..255");
  end

  state_t              state_q;
  logic                cmd_ready_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;
`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0]          tcnt_q;
`endif

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tcnt_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            pwrite_q    <= cmd_write;
            paddr_q     <= cmd_addr;
            pwdata_q    <= cmd_wdata;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          tcnt_q    <= '0;
`endif
        end
        ACCESS: begin
          // pready has priority over a timeout landing on the same edge
          if (pready) begin
            rsp_rdata_q <= pwrite_q ? '0 : prdata;
            rsp_err_q   <= pslverr;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
`ifdef APB_TIMEOUT_EN
          else if (tcnt_q == TO_LAST) begin
            tcnt_q      <= tcnt_q + 8'd1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: inputs driven and outputs checked on the falling edge of pclk.
module tb_apb_master_bridge;

  logic       pclk = 1'b0;
  logic       preset_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_rdata;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready, pslverr;

  int nvec = 0;
  int nerr = 0;

  apb_master_bridge #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    @(negedge pclk);
  endtask

  task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] data);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
  endtask

  initial begin
    preset_n  = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    rsp_ready = 1'b1; prdata = 8'h00; pready = 1'b0; pslverr = 1'b0;
    @(posedge pclk); @(posedge pclk); @(negedge pclk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_paddr", paddr, 8'h00);
    check("rst_rdata", rsp_rdata, 8'h00);
    preset_n = 1'b1;
    tick();
    check("idle_cmd_ready", cmd_ready, 1);

    // write 0xA5 to 0x03, zero-wait slave
    issue(1'b1, 8'h03, 8'hA5);
    pready = 1'b1; prdata = 8'h77;
    tick();
    cmd_valid = 1'b0;
    check("w_setup_psel", psel, 1);
    check("w_setup_penable", penable, 0);
    check("w_setup_pwrite", pwrite, 1);
    check("w_setup_paddr", paddr, 8'h03);
    check("w_setup_pwdata", pwdata, 8'hA5);
    check("w_setup_cmd_ready", cmd_ready, 0);
    tick();
    check("w_access_psel", psel, 1);
    check("w_access_penable", penable, 1);
    check("w_access_pwdata", pwdata, 8'hA5);
    tick();
    check("w_resp_psel", psel, 0);
    check("w_resp_penable", penable, 0);
    check("w_resp_valid", rsp_valid, 1);
    check("w_resp_err", rsp_err, 0);
    check("w_resp_rdata", rsp_rdata, 8'h00);
    check("w_resp_cmd_ready", cmd_ready, 0);
    tick();
    check("w_done_valid", rsp_valid, 0);
    check("w_done_cmd_ready", cmd_ready, 1);

    // read 0x03, three wait states, garbage on prdata/pslverr while not ready
    issue(1'b0, 8'h03, 8'h00);
    pready = 1'b0; prdata = 8'hFF; pslverr = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("r_setup_psel", psel, 1);
    check("r_setup_pwrite", pwrite, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("r_wait_penable", penable, 1);
      check("r_wait_psel", psel, 1);
      check("r_wait_paddr", paddr, 8'h03);
      check("r_wait_rsp_valid", rsp_valid, 0);
      tick();
    end
    check("r_last_penable", penable, 1);
    pready = 1'b1; prdata = 8'hA5; pslverr = 1'b0;
    tick();
    check("r_resp_valid", rsp_valid, 1);
    check("r_resp_rdata", rsp_rdata, 8'hA5);
    check("r_resp_err", rsp_err, 0);
    check("r_resp_penable", penable, 0);
    tick();
    check("r_done_cmd_ready", cmd_ready, 1);

    // write 0x10 with slave error
    issue(1'b1, 8'h10, 8'h3C);
    pready = 1'b1; pslverr = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("e_resp_valid", rsp_valid, 1);
    check("e_resp_err", rsp_err, 1);
    check("e_resp_rdata", rsp_rdata, 8'h00);
    pslverr = 1'b0;
    tick();
    check("e_done_cmd_ready", cmd_ready, 1);

    // read 0x22 with response back-pressure; next command must wait
    issue(1'b0, 8'h22, 8'h00);
    pready = 1'b1; prdata = 8'h5A; rsp_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    prdata = 8'h99;
    issue(1'b1, 8'h66, 8'h11);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, 8'h5A);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_psel", psel, 0);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    check("bp_held_valid", rsp_valid, 1);
    tick();
    check("bp_done_valid", rsp_valid, 0);
    check("bp_done_cmd_ready", cmd_ready, 1);
    check("bp_no_stray_psel", psel, 0);
    tick();
    check("bp_idle_psel", psel, 0);

    // reset during ACCESS of a read
    issue(1'b0, 8'h44, 8'h00);
    pready = 1'b0; prdata = 8'hAA;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("rr_access_penable", penable, 1);
    #2 preset_n = 1'b0;
    #1;
    check("rr_async_psel", psel, 0);
    check("rr_async_penable", penable, 0);
    check("rr_async_rsp_valid", rsp_valid, 0);
    check("rr_async_cmd_ready", cmd_ready, 1);
    @(negedge pclk);
    preset_n = 1'b1;
    pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rr_after_rsp_valid", rsp_valid, 0);
      check("rr_after_psel", psel, 0);
      check("rr_after_cmd_ready", cmd_ready, 1);
    end

`ifdef APB_TIMEOUT_EN
    // stuck slave: abort after 4 ACCESS cycles
    issue(1'b0, 8'h55, 8'h00);
    pready = 1'b0; prdata = 8'hEE;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("to_wait_psel", psel, 1);
      check("to_wait_penable", penable, 1);
      tick();
    end
    check("to_psel", psel, 0);
    check("to_penable", penable, 0);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_rdata", rsp_rdata, 8'h00);
    tick();
    check("to_done_cmd_ready", cmd_ready, 1);

    // pready on the fourth ACCESS edge completes normally
    issue(1'b0, 8'h56, 8'h00);
    pready = 1'b0; prdata = 8'h3D;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick(); tick(); tick();
    check("tw_last_penable", penable, 1);
    pready = 1'b1;
    tick();
    check("tw_rsp_valid", rsp_valid, 1);
    check("tw_rsp_err", rsp_err, 0);
    check("tw_rsp_rdata", rsp_rdata, 8'h3D);
    tick();
`else
    // no timeout: ACCESS waits indefinitely for pready
    issue(1'b0, 8'h55, 8'h00);
    pready = 1'b0; prdata = 8'hEE;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      check("nt_wait_psel", psel, 1);
      check("nt_wait_penable", penable, 1);
      check("nt_wait_rsp_valid", rsp_valid, 0);
      tick();
    end
    pready = 1'b1;
    tick();
    check("nt_rsp_valid", rsp_valid, 1);
    check("nt_rsp_err", rsp_err, 0);
    check("nt_rsp_rdata", rsp_rdata, 8'hEE);
    tick();
    check("nt_done_cmd_ready", cmd_ready, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Requester (initiator) end of the team's APB register bus; drives psel/penable/pwrite/paddr/pwdata into register-file slaves.
- Accepts one command at a time from a local valid/ready command port.
- Runs the two-phase APB transfer (SETUP, ACCESS, wait on pready) and returns read data and an error flag on a valid/ready response port.
- Sits between a control sequencer or CPU-side logic and 8-bit APB peripherals.

Parameters:
- ADDR_W, 8, width of cmd_addr/paddr.
- DATA_W, 8, width of wdata/rdata buses.
- TIMEOUT, 16, max ACCESS-phase cycles waiting for pready (used only with APB_TIMEOUT_EN); legal range 1..255.

Ports:
- pclk  in  1  clock, rising edge.
- preset_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  bridge can accept command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  pslverr sampled, or timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Single clock pclk; reset preset_n is asynchronous, active-low. All outputs are registered.
- Reset values: state = IDLE; cmd_ready = 1; psel, penable, pwrite, rsp_valid, rsp_err = 0; paddr, pwdata, rsp_rdata = 0; timeout counter = 0.
- Reset asserted mid-transfer aborts immediately: psel/penable drop asynchronously and no response is produced.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready at edge N: capture cmd_write/addr/wdata into pwrite/paddr/pwdata; cmd_ready -> 0; go to SETUP.
  - psel = 1, penable = 0 visible from cycle N+1.
- SETUP:
  - Lasts exactly one cycle, then ACCESS; penable = 1 from cycle N+2.
  - psel, pwrite, paddr, pwdata are held stable from SETUP through the end of ACCESS.
- ACCESS:
  - pready sampled every edge.
  - On pready = 1: capture rsp_rdata = prdata for reads (0 for writes) and rsp_err = pslverr.
  - On that same edge: psel, penable -> 0; rsp_valid -> 1; go to RESP.
  - pslverr and prdata are ignored while pready = 0.
- RESP:
  - rsp_valid, rsp_rdata, rsp_err held until rsp_valid & rsp_ready.
  - On that edge: rsp_valid -> 0, cmd_ready -> 1, go to IDLE.
  - rsp_ready may already be high on entry; the handshake then completes on the first RESP edge.
- Minimum transfer timing:
  - Zero-wait slave, rsp_ready tied high: command accept at edge N, pready sampled at N+2, rsp_valid high in cycle N+3, cmd_ready high in cycle N+4.
  - psel is always low for at least 2 cycles between transfers, so there are no back-to-back SETUP phases.
- cmd_valid while cmd_ready = 0 is ignored; the requester must hold its command until accepted.
- A slave that keeps pready high continuously is legal; it is only sampled in ACCESS.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on SETUP->ACCESS and increments each ACCESS cycle with pready = 0.
  - When the counter reaches TIMEOUT without pready: psel/penable -> 0, rsp_err = 1, rsp_rdata = 0, go to RESP.
  - If pready = 1 on the same edge the counter would reach TIMEOUT, pready wins (normal completion).
- Undefined: no counter; ACCESS waits indefinitely for pready.

Test Plan:
- Write 0xA5 to addr 0x03, zero-wait slave, rsp_ready = 1 -> psel high 2 cycles, penable high 1 cycle, pwdata = 0xA5 stable both cycles; rsp_valid pulse with rsp_err = 0, rsp_rdata = 0x00.
- Read addr 0x03 from a slave returning 0xA5 after 3 wait cycles -> penable high 4 cycles, paddr = 0x03 held; rsp_rdata = 0xA5, rsp_err = 0.
- Write to addr 0x10 with slave asserting pslverr = 1 with pready -> rsp_err = 1; next command accepted normally.
- rsp_ready low for 5 cycles after response -> rsp_valid and rsp_rdata held stable, cmd_ready stays 0, psel stays 0; completes on rsp_ready.
- preset_n pulsed low during ACCESS of a read -> psel, penable, rsp_valid = 0 immediately; cmd_ready = 1 after release; no stale response.
- With APB_TIMEOUT_EN, TIMEOUT = 4, pready stuck low -> psel drops after 4 ACCESS cycles, rsp_err = 1, rsp_rdata = 0x00.
